// File: rtl/rhs_spi_array_master.sv
// SPI master for an array of RHS chips: one shared CS/SCLK pair and one
// MOSI/MISO lane per chip. A shared sample-tick delay line lets each lane
// sample its MISO a configurable number of clk cycles after the SCLK rising
// edge, which absorbs the per-lane board and cable round-trip delay.
module rhs_spi_array_master #(
  parameter int NUM_CHIPS      = 16,
  parameter int WORD_BITS      = 32,
  parameter int HALF_PERIOD    = 2,
  parameter int MAX_OFFSET     = 15,
  parameter int CS_HIGH_CYCLES = 4,
  localparam int OW = (MAX_OFFSET > 0) ? $clog2(MAX_OFFSET + 1) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_broadcast,
  input  logic [NUM_CHIPS*WORD_BITS-1:0] cmd_word,
  input  logic [NUM_CHIPS*OW-1:0]        oversample_offset,
  output logic                           rsp_valid,
  output logic [NUM_CHIPS*WORD_BITS-1:0] rsp_data,
  output logic                           busy,
  output logic                           CS,
  output logic                           SCLK,
  output logic [NUM_CHIPS-1:0]           MOSI,
  input  logic [NUM_CHIPS-1:0]           MISO
);

  // Delay line needs at least one stage even if no offset range is requested.
  localparam int DLY_W = (MAX_OFFSET > 0) ? MAX_OFFSET : 1;
  localparam int PW    = (2 * HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
  localparam int BW    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, GAP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_cnt, w_cnt_nxt;
  logic [PW-1:0]          r_ph, w_ph_nxt;
  logic [BW-1:0]          r_bit, w_bit_nxt;
  logic                   w_accept;
  logic                   w_tick;
  logic                   w_rsp_fire;

  logic [WORD_BITS-1:0]   r_words   [NUM_CHIPS];
  logic [WORD_BITS-1:0]   w_word_in [NUM_CHIPS];
  logic [WORD_BITS-1:0]   w_word_sel[NUM_CHIPS];
  logic [OW-1:0]          r_off     [NUM_CHIPS];
  logic [OW-1:0]          w_off_in  [NUM_CHIPS];
  logic [WORD_BITS-1:0]   r_cap     [NUM_CHIPS];
  logic [WORD_BITS-1:0]   w_cap_nxt [NUM_CHIPS];
  logic [DLY_W-1:0]       r_dly;
  logic [DLY_W:0]         w_taps;

  logic                   r_cs, r_sclk, r_busy, r_rsp_valid;
  logic [NUM_CHIPS-1:0]   r_mosi;
  logic [NUM_CHIPS*WORD_BITS-1:0] r_rsp_data;
  logic                   w_cs_nxt, w_sclk_nxt;
  logic [NUM_CHIPS-1:0]   w_mosi_nxt;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_tick    = (r_state == SHIFT) && (r_ph == PW'(HALF_PERIOD));
  assign w_rsp_fire = (w_state_nxt == GAP) && (r_state != GAP);

  assign CS        = r_cs;
  assign SCLK      = r_sclk;
  assign MOSI      = r_mosi;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  // Broadcast expansion and offset clamping of the incoming command
  always_comb begin
    for (int c = 0; c < NUM_CHIPS; c++) begin
      w_word_in[c]  = cmd_broadcast ? cmd_word[0 +: WORD_BITS]
                                    : cmd_word[c*WORD_BITS +: WORD_BITS];
      w_off_in[c]   = (oversample_offset[c*OW +: OW] > OW'(MAX_OFFSET))
                      ? OW'(MAX_OFFSET) : oversample_offset[c*OW +: OW];
      w_word_sel[c] = w_accept ? w_word_in[c] : r_words[c];
    end
  end

  // Next-state logic: frame sequencing and bit/phase counters
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ph_nxt    = r_ph;
    w_bit_nxt   = r_bit;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = LEAD;
          w_cnt_nxt   = '0;
          w_ph_nxt    = '0;
          w_bit_nxt   = '0;
        end
      end
      LEAD: begin
        if (r_cnt == 16'(HALF_PERIOD - 1)) begin
          w_state_nxt = SHIFT;
          w_ph_nxt    = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      SHIFT: begin
        if (r_ph == PW'(2 * HALF_PERIOD - 1)) begin
          w_ph_nxt = '0;
          if (r_bit == BW'(WORD_BITS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (MAX_OFFSET > 0) ? TAIL : GAP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
      TAIL: begin
        if (r_cnt == 16'(MAX_OFFSET - 1)) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      GAP: begin
        if (r_cnt == 16'(CS_HIGH_CYCLES - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state
  always_comb begin
    w_cs_nxt   = 1'b1;
    w_sclk_nxt = 1'b0;
    w_mosi_nxt = '0;
    if (w_state_nxt == LEAD || w_state_nxt == SHIFT || w_state_nxt == TAIL)
      w_cs_nxt = 1'b0;
    if (w_state_nxt == SHIFT && w_ph_nxt >= PW'(HALF_PERIOD))
      w_sclk_nxt = 1'b1;
    if (w_state_nxt == LEAD || w_state_nxt == SHIFT) begin
      for (int c = 0; c < NUM_CHIPS; c++)
        w_mosi_nxt[c] = w_word_sel[c][BW'(WORD_BITS - 1) - w_bit_nxt];
    end
  end

  // Tap select and per-lane MISO shift-in; tap 0 is the undelayed tick
  always_comb begin
    w_taps = {r_dly, w_tick};
    for (int c = 0; c < NUM_CHIPS; c++)
      w_cap_nxt[c] = w_taps[r_off[c]] ? {r_cap[c][WORD_BITS-2:0], MISO[c]} : r_cap[c];
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ph        <= '0;
      r_bit       <= '0;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ph        <= w_ph_nxt;
      r_bit       <= w_bit_nxt;
      r_cs        <= w_cs_nxt;
      r_sclk      <= w_sclk_nxt;
      r_mosi      <= w_mosi_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_rsp_valid <= w_rsp_fire;
      // Take the capture next-value so a last-cycle capture is not missed
      if (w_rsp_fire) begin
        for (int c = 0; c < NUM_CHIPS; c++)
          r_rsp_data[c*WORD_BITS +: WORD_BITS] <= w_cap_nxt[c];
      end
    end
  end

  // Tick delay line, lane offsets and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly <= '0;
      for (int c = 0; c < NUM_CHIPS; c++) begin
        r_cap[c] <= '0;
        r_off[c] <= '0;
      end
    end else begin
      r_dly <= w_taps[DLY_W-1:0];
      for (int c = 0; c < NUM_CHIPS; c++) begin
        r_cap[c] <= w_accept ? '0 : w_cap_nxt[c];
        if (w_accept)
          r_off[c] <= w_off_in[c];
      end
    end
  end

  // Command words are latched on accept only
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < NUM_CHIPS; c++)
        r_words[c] <= w_word_in[c];
    end
  end

endmodule

// File: tb/tb_rhs_spi_array_master.sv
// Directed bench for rhs_spi_array_master: a 4-lane instance with a
// delayed-loopback slave, plus a 1-lane instance with a non-power-of-two
// offset range so that the offset clamp can be exercised.
module tb_rhs_spi_array_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_broadcast = 1'b0;
  logic [127:0] cmd_word = '0;
  logic [11:0]  oversample_offset = '0;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         busy, CS, SCLK;
  logic [3:0]   MOSI;
  logic [3:0]   MISO;

  logic         c2_valid = 1'b0;
  logic         c2_ready;
  logic [7:0]   c2_word = '0;
  logic [2:0]   c2_off = '0;
  logic         c2_rsp_valid;
  logic [7:0]   c2_rsp_data;
  logic         c2_busy, c2_cs, c2_sclk;
  logic [0:0]   c2_mosi;
  logic [0:0]   c2_miso;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rhs_spi_array_master #(
    .NUM_CHIPS(4), .WORD_BITS(32), .HALF_PERIOD(2), .MAX_OFFSET(7), .CS_HIGH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_broadcast(cmd_broadcast), .cmd_word(cmd_word),
    .oversample_offset(oversample_offset), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .CS(CS), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO)
  );

  rhs_spi_array_master #(
    .NUM_CHIPS(1), .WORD_BITS(8), .HALF_PERIOD(1), .MAX_OFFSET(5), .CS_HIGH_CYCLES(1)
  ) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_broadcast(1'b0), .cmd_word(c2_word),
    .oversample_offset(c2_off), .rsp_valid(c2_rsp_valid),
    .rsp_data(c2_rsp_data), .busy(c2_busy), .CS(c2_cs), .SCLK(c2_sclk),
    .MOSI(c2_mosi), .MISO(c2_miso)
  );

  // Slave model: each lane returns its own MOSI delayed by dly[c] clk cycles
  logic [15:0] hist [4];
  int          dly  [4];
  logic [7:0]  hist2;

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) hist[c] <= {hist[c][14:0], MOSI[c]};
    hist2 <= {hist2[6:0], c2_mosi[0]};
  end

  always_comb begin
    MISO = '0;
    for (int c = 0; c < 4; c++)
      MISO[c] = (dly[c] == 0) ? MOSI[c] : hist[c][dly[c]-1];
  end

  assign c2_miso[0] = hist2[4];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Run one frame on the 4-lane instance; called and returning at a negedge.
  // Cycle 0 is the accept cycle; inputs are scrambled after accept.
  task automatic run_frame(input logic [127:0] words, input logic [11:0] offs,
                           input logic bc, output logic [127:0] rsp,
                           output int t_rsp, output int t_rdy, output int t_rise,
                           output int n_rise, output logic [127:0] mon);
    int   guard;
    logic prev;
    t_rsp = -1; t_rdy = -1; t_rise = -1; n_rise = 0; rsp = '0; mon = '0;
    guard = 0;
    while (!cmd_ready && guard < 400) begin @(negedge clk); guard++; end
    cmd_word = words; oversample_offset = offs; cmd_broadcast = bc; cmd_valid = 1'b1;
    prev = 1'b0;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_word = ~words; oversample_offset = '0; cmd_broadcast = ~bc;
      end
      if (SCLK && !prev) begin
        n_rise++;
        if (t_rise < 0) t_rise = k;
        for (int c = 0; c < 4; c++)
          mon[c*32 +: 32] = {mon[c*32 +: 31], MOSI[c]};
      end
      prev = SCLK;
      if (rsp_valid) begin
        if (t_rsp < 0) begin t_rsp = k; rsp = rsp_data; end
        else t_rsp = -2;
      end
      if (cmd_ready) begin t_rdy = k; break; end
    end
  endtask

  logic [127:0] w, r, m, exp_w;
  int           tr, ty, tf, nr, t2, ty2;
  logic [7:0]   r2;
  logic         seen;

  initial begin
    for (int c = 0; c < 4; c++) dly[c] = 0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_cs", CS, 1'b1);
      chk("rst_sclk", SCLK, 1'b0);
      chk("rst_mosi", MOSI, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);
    chk("rsp_data_rst", rsp_data, 128'h0);

    // Per-lane words, loopback, zero offsets
    w = {32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'hDEADBEEF};
    run_frame(w, 12'h000, 1'b0, r, tr, ty, tf, nr, m);
    chk("f1_pulses", nr, 32);
    chk("f1_first_rise", tf, 5);
    chk("f1_rsp_cycle", tr, 138);
    chk("f1_ready_cycle", ty, 142);
    chk("f1_rsp_data", r, w);
    chk("f1_mosi_words", m, w);
    chk("f1_rsp_hold", rsp_data, w);

    // Per-lane slave delays 0,2,4,6 matched by offsets
    dly[0] = 0; dly[1] = 2; dly[2] = 4; dly[3] = 6;
    w = {32'hCAFEF00D, 32'h0F0F0F0F, 32'h80000001, 32'h13579BDF};
    run_frame(w, {3'd6, 3'd4, 3'd2, 3'd0}, 1'b0, r, tr, ty, tf, nr, m);
    chk("f2_offsets", r, w);
    chk("f2_ready_cycle", ty, 142);

    // Lane 3 offset 0 against a 6-cycle delay: each bit lands one place late
    exp_w = {32'h657F7806, 32'h0F0F0F0F, 32'h80000001, 32'h13579BDF};
    run_frame(w, {3'd0, 3'd4, 3'd2, 3'd0}, 1'b0, r, tr, ty, tf, nr, m);
    chk("f3_lane3_corrupt", r, exp_w);

    // Broadcast of lane 0 word
    for (int c = 0; c < 4; c++) dly[c] = 0;
    w = {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
    run_frame(w, 12'h000, 1'b1, r, tr, ty, tf, nr, m);
    chk("f4_bcast_mosi", m, {4{32'hA5A5A5A5}});
    chk("f4_bcast_rsp", r, {4{32'hA5A5A5A5}});

    // Reset pulsed at cycle 60 of a frame
    seen = 1'b0;
    cmd_word = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    oversample_offset = '0; cmd_broadcast = 1'b0; cmd_valid = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    chk("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cs", CS, 1'b1);
    chk("mid_sclk", SCLK, 1'b0);
    chk("mid_mosi", MOSI, 4'h0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rsp_data", rsp_data, 128'h0);
    rst = 1'b0;
    repeat (160) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 1'b0);
    w = {32'h0BADC0DE, 32'hFEEDFACE, 32'h00FF00FF, 32'h76543210};
    run_frame(w, 12'h000, 1'b0, r, tr, ty, tf, nr, m);
    chk("f6_ready_cycle", ty, 142);
    chk("f6_rsp_data", r, w);

    // Offset clamp: 3-bit field value 7 on a MAX_OFFSET=5 instance, slave delay 5
    t2 = -1; ty2 = -1; r2 = '0;
    c2_word = 8'hB4; c2_off = 3'd7; c2_valid = 1'b1;
    for (int k = 1; k < 80; k++) begin
      @(negedge clk);
      if (k == 1) begin c2_valid = 1'b0; c2_word = 8'h00; c2_off = 3'd0; end
      if (c2_rsp_valid && t2 < 0) begin t2 = k; r2 = c2_rsp_data; end
      if (c2_ready) begin ty2 = k; break; end
    end
    chk("clamp_rsp_cycle", t2, 23);
    chk("clamp_ready_cycle", ty2, 24);
    chk("clamp_rsp_data", r2, 8'hB4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
